add_accum: RTL and testbench

- Streaming accumulating adder. Sums COUNT unsigned IN_SIZE-bit samples into one OUT_SIZE-bit result.
- Valid/ready handshake on input and result sides; sticky overflow per frame.
- Successor to the combinational two-operand adder. Sits between sample producers and downstream averaging/decimation logic in the math library.

---
 rtl/add_accum.sv | 105 ++++++++++
 tb/tb_add_accum.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_accum.sv
// add_accum: streaming accumulating adder.
// Sums COUNT unsigned IN_SIZE-bit samples into one OUT_SIZE-bit result,
// using a valid/ready handshake on both the sample and the result side.
// The overflow flag is sticky for the whole frame.
// Optional build macro ADD_SATURATE_EN: when it is defined, the accumulator
// saturates at all ones. When it is undefined, the accumulator wraps.
module add_accum #(
   parameter int IN_SIZE  = 8,
   parameter int OUT_SIZE = 16,
   parameter int COUNT    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [IN_SIZE-1:0]           a,
   input  logic                         a_valid,
   output logic                         a_ready,
   input  logic                         clear,
   output logic [OUT_SIZE-1:0]          c,
   output logic                         c_valid,
   input  logic                         c_ready,
   output logic                         overflow,
   output logic [$clog2(COUNT+1)-1:0]   sample_cnt
);

   localparam int              CNT_W    = $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

   typedef enum logic {
      ST_ACC,
      ST_HOLD
   } state_t;

   state_t              r_state;
   logic [OUT_SIZE-1:0] r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ovf;

   logic                w_accept;
   logic [OUT_SIZE:0]   w_sum;
   logic [OUT_SIZE-1:0] w_next_acc;

   // NOTE: a_ready depends combinationally on clear, so a sample offered in
   // the same cycle as a clear is refused rather than lost inside the frame.
   assign a_ready  = (r_state == ST_ACC) && !clear;
   assign w_accept = a_valid && a_ready;

   // Both operands are zero-extended to OUT_SIZE+1 bits, so the top bit of
   // the sum is the carry out of the accumulator.
   assign w_sum = {1'b0, r_acc} + {{(OUT_SIZE + 1 - IN_SIZE){1'b0}}, a};

   // Choose the next accumulator value: saturate or wrap, depending on the build.
   always_comb begin
`ifdef ADD_SATURATE_EN
      // Once the frame has overflowed, hold all ones until the frame ends.
      w_next_acc = (w_sum[OUT_SIZE] || r_ovf) ? {OUT_SIZE{1'b1}} : w_sum[OUT_SIZE-1:0];
`else
      w_next_acc = w_sum[OUT_SIZE-1:0];
`endif
   end

   // Frame FSM: accumulate in ACC, then present the result in HOLD until it is taken or cleared.
   always_ff @(posedge clk) begin
      // NOTE: all state is updated with non-blocking assignments, so every
      // register samples the pre-edge values no matter the statement order.
      if (rst) begin
         r_state <= ST_ACC;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_ACC: begin
               if (clear) begin
                  r_acc <= '0;
                  r_cnt <= '0;
                  r_ovf <= 1'b0;
               end else if (w_accept) begin
                  r_acc <= w_next_acc;
                  r_ovf <= r_ovf | w_sum[OUT_SIZE];
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_CNT) begin
                     r_state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               // clear and a consumer handshake both end the frame the same way;
               // the difference is only whether the result was delivered.
               if (clear || c_ready) begin
                  r_state <= ST_ACC;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign c          = r_acc;
   assign c_valid    = (r_state == ST_HOLD);
   assign overflow   = r_ovf;
   assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: directed bench for add_accum.
// u_dut4 is built with IN_SIZE=8, OUT_SIZE=10, COUNT=4.
// u_dut5 is built with IN_SIZE=8, OUT_SIZE=10, COUNT=5.
// Inputs change on the falling edge and outputs are sampled 1 ns later,
// so every check sees the state left by the previous rising edge.
module tb_add_accum;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic [7:0] a4 = '0;
   logic       a_valid4 = 1'b0;
   logic       clear4 = 1'b0;
   logic       c_ready4 = 1'b0;
   logic       a_ready4;
   logic [9:0] c4;
   logic       c_valid4;
   logic       overflow4;
   logic [2:0] cnt4;

   logic [7:0] a5 = '0;
   logic       a_valid5 = 1'b0;
   logic       clear5 = 1'b0;
   logic       c_ready5 = 1'b0;
   logic       a_ready5;
   logic [9:0] c5;
   logic       c_valid5;
   logic       overflow5;
   logic [2:0] cnt5;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       av;
      logic [7:0] a;
      logic       clr;
      logic       cr;
      logic [9:0] exp_c;
      logic       exp_cv;
      logic       exp_ar;
      logic       exp_ov;
      logic [2:0] exp_cnt;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   add_accum #(.IN_SIZE(8), .OUT_SIZE(10), .COUNT(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .a(a4), .a_valid(a_valid4), .a_ready(a_ready4), .clear(clear4),
      .c(c4), .c_valid(c_valid4), .c_ready(c_ready4),
      .overflow(overflow4), .sample_cnt(cnt4)
   );

   add_accum #(.IN_SIZE(8), .OUT_SIZE(10), .COUNT(5)) u_dut5 (
      .clk(clk), .rst(rst),
      .a(a5), .a_valid(a_valid5), .a_ready(a_ready5), .clear(clear5),
      .c(c5), .c_valid(c_valid5), .c_ready(c_ready5),
      .overflow(overflow5), .sample_cnt(cnt5)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive4(input logic av, input logic [7:0] v, input logic clr, input logic cr);
      @(negedge clk);
      a_valid4 = av;
      a4       = v;
      clear4   = clr;
      c_ready4 = cr;
      #1;
   endtask

   task automatic drive5(input logic av, input logic [7:0] v, input logic clr, input logic cr);
      @(negedge clk);
      a_valid5 = av;
      a5       = v;
      clear5   = clr;
      c_ready5 = cr;
      #1;
   endtask

   // Offers one sample to u_dut4 and confirms that it is accepted this cycle.
   task automatic feed4(input string name, input logic [7:0] v, input logic cr);
      drive4(1'b1, v, 1'b0, cr);
      check({name, ".a_ready"}, 32'(a_ready4), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      a_valid4 = 1'b0; clear4 = 1'b0; c_ready4 = 1'b0;
      a_valid5 = 1'b0; clear5 = 1'b0; c_ready5 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- 1: reset held for 2 cycles while a sample is offered ----
      @(negedge clk);
      rst = 1'b1;
      a_valid4 = 1'b1; a4 = 8'hFF;
      a_valid5 = 1'b1; a5 = 8'hFF;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst.c",        32'(c4),        32'd0);
      check("rst.c_valid",  32'(c_valid4),  32'd0);
      check("rst.overflow", 32'(overflow4), 32'd0);
      check("rst.cnt",      32'(cnt4),      32'd0);
      check("rst.c5",       32'(c5),        32'd0);
      rst = 1'b0;
      a_valid4 = 1'b0;
      a_valid5 = 1'b0;
      #1;
      check("rst.a_ready",  32'(a_ready4),  32'd1);
      check("rst.a_ready5", 32'(a_ready5),  32'd1);

      // ---- 2: frame 10,20,30,40 with c_ready=1 ----
      // Each row gives the inputs for one cycle and the outputs expected
      // before the clock edge that follows.
      tbl[0] = '{1'b1, 8'd10, 1'b0, 1'b1, 10'd0,   1'b0, 1'b1, 1'b0, 3'd0};
      tbl[1] = '{1'b1, 8'd20, 1'b0, 1'b1, 10'd10,  1'b0, 1'b1, 1'b0, 3'd1};
      tbl[2] = '{1'b1, 8'd30, 1'b0, 1'b1, 10'd30,  1'b0, 1'b1, 1'b0, 3'd2};
      tbl[3] = '{1'b1, 8'd40, 1'b0, 1'b1, 10'd60,  1'b0, 1'b1, 1'b0, 3'd3};
      tbl[4] = '{1'b1, 8'd50, 1'b0, 1'b1, 10'd100, 1'b1, 1'b0, 1'b0, 3'd4};
      tbl[5] = '{1'b1, 8'd50, 1'b0, 1'b1, 10'd0,   1'b0, 1'b1, 1'b0, 3'd0};
      tbl[6] = '{1'b0, 8'd0,  1'b0, 1'b1, 10'd50,  1'b0, 1'b1, 1'b0, 3'd1};
      for (int i = 0; i < 7; i++) begin
         drive4(tbl[i].av, tbl[i].a, tbl[i].clr, tbl[i].cr);
         check($sformatf("t2[%0d].c", i),        32'(c4),        32'(tbl[i].exp_c));
         check($sformatf("t2[%0d].c_valid", i),  32'(c_valid4),  32'(tbl[i].exp_cv));
         check($sformatf("t2[%0d].a_ready", i),  32'(a_ready4),  32'(tbl[i].exp_ar));
         check($sformatf("t2[%0d].overflow", i), 32'(overflow4), 32'(tbl[i].exp_ov));
         check($sformatf("t2[%0d].cnt", i),      32'(cnt4),      32'(tbl[i].exp_cnt));
      end

      // ---- 3: five samples of 255 into OUT_SIZE=10 (u_dut5) ----
      for (int i = 0; i < 5; i++) begin
         drive5(1'b1, 8'd255, 1'b0, 1'b0);
         check($sformatf("t3[%0d].a_ready", i), 32'(a_ready5), 32'd1);
         check($sformatf("t3[%0d].c", i),       32'(c5),       32'(255 * i));
      end
      drive5(1'b0, 8'd0, 1'b0, 1'b0);
`ifdef ADD_SATURATE_EN
      check("t3.c_sat",  32'(c5), 32'd1023);
`else
      check("t3.c_wrap", 32'(c5), 32'd251);
`endif
      check("t3.overflow", 32'(overflow5), 32'd1);
      check("t3.c_valid",  32'(c_valid5),  32'd1);
      check("t3.cnt",      32'(cnt5),      32'd5);
      drive5(1'b0, 8'd0, 1'b0, 1'b1);
      drive5(1'b0, 8'd0, 1'b0, 1'b0);
      check("t3.post.c_valid",  32'(c_valid5),  32'd0);
      check("t3.post.overflow", 32'(overflow5), 32'd0);
      check("t3.post.c",        32'(c5),        32'd0);

      // ---- 4: backpressure while a=7 is offered ----
      do_reset();
      for (int i = 0; i < 4; i++) feed4($sformatf("t4.feed%0d", i), 8'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive4(1'b1, 8'd7, 1'b0, 1'b0);
         check($sformatf("t4.hold%0d.c", i),       32'(c4),       32'd4);
         check($sformatf("t4.hold%0d.c_valid", i), 32'(c_valid4), 32'd1);
         check($sformatf("t4.hold%0d.a_ready", i), 32'(a_ready4), 32'd0);
         check($sformatf("t4.hold%0d.cnt", i),     32'(cnt4),     32'd4);
      end
      drive4(1'b1, 8'd7, 1'b0, 1'b1);
      check("t4.take.c_valid", 32'(c_valid4), 32'd1);
      check("t4.take.c",       32'(c4),       32'd4);
      drive4(1'b1, 8'd7, 1'b0, 1'b1);
      check("t4.next.c_valid", 32'(c_valid4), 32'd0);
      check("t4.next.a_ready", 32'(a_ready4), 32'd1);
      check("t4.next.c",       32'(c4),       32'd0);
      drive4(1'b0, 8'd0, 1'b0, 1'b1);
      check("t4.first.c",   32'(c4),   32'd7);
      check("t4.first.cnt", 32'(cnt4), 32'd1);

      // ---- 5: clear during ACC, then clear during HOLD ----
      do_reset();
      feed4("t5.f5", 8'd5, 1'b1);
      feed4("t5.f6", 8'd6, 1'b1);
      drive4(1'b1, 8'd9, 1'b1, 1'b1);
      check("t5.clr.a_ready", 32'(a_ready4), 32'd0);
      check("t5.clr.c",       32'(c4),       32'd11);
      check("t5.clr.cnt",     32'(cnt4),     32'd2);
      feed4("t5.f1", 8'd1, 1'b0);
      check("t5.after_clr.c",   32'(c4),   32'd0);
      check("t5.after_clr.cnt", 32'(cnt4), 32'd0);
      feed4("t5.f2", 8'd2, 1'b0);
      feed4("t5.f3", 8'd3, 1'b0);
      feed4("t5.f4", 8'd4, 1'b0);
      drive4(1'b0, 8'd0, 1'b0, 1'b0);
      check("t5.res.c",        32'(c4),        32'd10);
      check("t5.res.c_valid",  32'(c_valid4),  32'd1);
      check("t5.res.overflow", 32'(overflow4), 32'd0);
      drive4(1'b0, 8'd0, 1'b1, 1'b1);
      check("t5.hclr.c_valid", 32'(c_valid4), 32'd1);
      drive4(1'b0, 8'd0, 1'b0, 1'b0);
      check("t5.drop.c_valid", 32'(c_valid4), 32'd0);
      check("t5.drop.c",       32'(c4),       32'd0);
      check("t5.drop.cnt",     32'(cnt4),     32'd0);
      drive4(1'b0, 8'd0, 1'b0, 1'b0);
      check("t5.drop2.c_valid", 32'(c_valid4), 32'd0);

      // ---- 6: reset partway through a frame ----
      do_reset();
      for (int i = 0; i < 3; i++) feed4($sformatf("t6.pre%0d", i), 8'd9, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      a_valid4 = 1'b1; a4 = 8'd9;
      @(negedge clk);
      rst = 1'b0;
      a_valid4 = 1'b0;
      #1;
      check("t6.rst.c",   32'(c4),   32'd0);
      check("t6.rst.cnt", 32'(cnt4), 32'd0);
      for (int i = 0; i < 4; i++) feed4($sformatf("t6.f%0d", i), 8'd2, 1'b0);
      drive4(1'b0, 8'd0, 1'b0, 1'b0);
      check("t6.res.c",        32'(c4),        32'd8);
      check("t6.res.c_valid",  32'(c_valid4),  32'd1);
      check("t6.res.overflow", 32'(overflow4), 32'd0);
      check("t6.res.cnt",      32'(cnt4),      32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
